alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Sequential arbiter that shares the single ALU between two requesters: requester 0 is the main datapath, requester 1 is an auxiliary unit such as an address or branch-compare unit. It accepts one operation at a time with a valid/ready handshake and picks the winner round-robin. It drives the registered operands and 5-bit ALU operation code onto the ALU, waits a fixed ALU latency, then returns the tagged result on a valid/ready response channel. The ALU operation codes are the ones produced by the ALU control decoder, for example 5'b00010 = ADD and 5'b10010 = SUB.

## Interface
- WIDTH, 32, operand and result width
- ALU_LAT, 1, number of EXEC cycles before the ALU result is sampled; legal range 1..15
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- req0_valid_i  in  1  requester 0 has an operation pending
- req0_ready_o  out  1  requester 0 operation accepted this cycle
- req0_a_i, req0_b_i  in  WIDTH  requester 0 operands
- req0_aluop_i  in  5  requester 0 ALU operation code
- req1_valid_i, req1_ready_o, req1_a_i, req1_b_i, req1_aluop_i  same as requester 0, for requester 1
- alu_a_o, alu_b_o  out  WIDTH  operands driven to the ALU
- alu_op_o  out  5  operation code driven to the ALU
- alu_result_i  in  WIDTH  ALU result (combinational from alu_*_o)
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  consumer accepts the response
- rsp_id_o  out  1  index of the requester that owns the response
- rsp_result_o  out  WIDTH  result of the operation
- busy_o  out  1  high whenever the state is not IDLE

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid_i is high, select a winner, assert only the winner's reqN_ready_o, and latch its a/b/aluop and id into registers.
  - Load the latency counter with 0 and go to EXEC.
  - If neither valid is high, stay in IDLE.
- Arbitration:
  - A single valid requester always wins.
  - If both are valid, the winner is the requester that was not granted most recently (last_q).
  - last_q is updated on every accept and resets to 1, so requester 0 wins the first tie.
- reqN_ready_o is combinational: (state == IDLE) and (winner == N). It is never high in EXEC or RESP.
- Requesters must hold valid and operands stable until ready is seen; the block does not require this for correctness, because it samples only on the accept cycle.
- EXEC:
  - alu_a_o, alu_b_o and alu_op_o come from the latched registers.
  - The counter increments each cycle.
  - When counter == ALU_LAT-1, capture alu_result_i into the result register and go to RESP.
- RESP:
  - rsp_valid_o = 1; rsp_id_o and rsp_result_o are held constant.
  - On rsp_valid_o && rsp_ready_i, go to IDLE.
  - With rsp_ready_i low, stay in RESP indefinitely and hold all outputs stable.
- alu_*_o always reflect the latched registers, in every state, so the ALU inputs only change at accept.
- No arithmetic is performed inside the block. The counter is 4 bits wide and never wraps, because ALU_LAT ≤ 15.

## Timing
- Reset values: state = IDLE, last_q = 1, counter = 0, all latched registers = 0. Therefore:
  - alu_a_o = alu_b_o = 0, alu_op_o = 5'b00000 (AND)
  - rsp_valid_o = 0, rsp_id_o = 0, rsp_result_o = 0, busy_o = 0
  - req0_ready_o and req1_ready_o are 0 while rst_ni is low.
- Latency:
  - Accept occurs in cycle T (ready high).
  - The ALU sees the new operands from T+1.
  - The result is captured at the end of cycle T+ALU_LAT.
  - rsp_valid_o rises in cycle T+ALU_LAT+1.
- Minimum spacing between accepts is ALU_LAT+2 cycles, with rsp_ready_i tied high.
- Simultaneous events:
  - The response handshake in RESP returns to IDLE; a new accept can happen in the very next cycle, not the same cycle.
  - A valid deasserting in IDLE drops its ready in the same cycle, with no accept.
- Reset mid-operation: asserting rst_ni low in EXEC or RESP immediately forces all outputs to their reset values. The in-flight operation and any pending response are discarded, and after reset release the block is in IDLE.

## Test plan
- Single request: req0 valid, a=5, b=3, aluop=00010, ALU_LAT=1 -> ready0 high in 1 cycle; 2 cycles later rsp_valid=1, id=0, result=8.
- Tie: both valid in the same cycle after reset, req0 SUB 10-4, req1 ADD 1+1 -> req0 is granted first (result 6, id 0), then req1 (result 2, id 1).
- Fairness: both held valid continuously for 6 operations -> grants alternate 0,1,0,1,0,1 and ready is never high in two consecutive cycles.
- Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid, id and result stay stable, busy=1, both readys stay 0; rsp_ready high -> IDLE the next cycle.
- Latency: ALU_LAT=3 with a model ALU, accept at T -> rsp_valid rises at T+4 and the result equals the ALU output at T+3.
- Reset: rst_ni low during EXEC -> rsp_valid=0 and busy=0 immediately, alu_op=0; after release no response is produced for the aborted operation.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one ALU between two
// requesters, fixed-latency execute and a valid/ready response.
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic [4:0]       req0_aluop_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    input  logic [4:0]       req1_aluop_i,

    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [4:0]       alu_op_o,
    input  logic [WIDTH-1:0] alu_result_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_result_o,

    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(ALU_LAT - 1);

    state_t           state_q;
    logic             last_q;
    logic             id_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [4:0]       op_q;

    logic             any_valid;
    logic             winner;
    logic             accept;

    assign any_valid = req0_valid_i | req1_valid_i;

    // Tie goes to whoever was not granted last; a lone requester always wins.
    always_comb begin
        winner = 1'b0;
        unique case (1'b1)
            req0_valid_i && req1_valid_i:  winner = ~last_q;
            req1_valid_i && !req0_valid_i: winner = 1'b1;
            default:                       winner = 1'b0;
        endcase
    end

    // Reset gating keeps both readys low while reset is held.
    assign accept       = rst_ni & (state_q == IDLE) & any_valid;
    assign req0_ready_o = accept & ~winner;
    assign req1_ready_o = accept & winner;

    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign alu_op_o     = op_q;

    assign rsp_valid_o  = (state_q == RESP);
    assign rsp_id_o     = id_q;
    assign rsp_result_o = res_q;
    assign busy_o       = (state_q != IDLE);

    // Control FSM: latch winner on accept, count ALU latency, hold response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            cnt_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 5'd0;
            res_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= winner ? req1_a_i : req0_a_i;
                        b_q     <= winner ? req1_b_i : req0_b_i;
                        op_q    <= winner ? req1_aluop_i : req0_aluop_i;
                        id_q    <= winner;
                        last_q  <= winner;
                        cnt_q   <= 4'd0;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT) begin
                        res_q   <= alu_result_i;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: random and directed stimulus against a
// cycle-level reference model with a response scoreboard.
module tb_alu_share_arbiter;

    localparam int W   = 32;
    localparam int LAT = 3;

    localparam logic [4:0] OP_AND = 5'b00000;
    localparam logic [4:0] OP_OR  = 5'b00001;
    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_XOR = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b10010;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic [4:0]   req0_op = '0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic [4:0]   req1_op = '0;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [4:0]   alu_op;
    logic [W-1:0] alu_result;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_id;
    logic [W-1:0] rsp_result;
    logic         busy;

    alu_share_arbiter #(.WIDTH(W), .ALU_LAT(LAT)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req0_aluop_i (req0_op),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .req1_aluop_i (req1_op),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_op_o     (alu_op),
        .alu_result_i (alu_result),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_result_o (rsp_result),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_model(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic [4:0] op);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_XOR:  return a ^ b;
            OP_SUB:  return a - b;
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_op);

    int errors = 0;
    int checks = 0;
    int accepts = 0;
    int pops = 0;
    int aborted = 0;
    int grants_seen = 0;

    logic [W:0] sb[$];

    // reference model state
    bit m_busy = 1'b0;
    bit m_last = 1'b1;
    int m_cyc = 0;
    int m_rsp_at = 0;
    bit exp_r0 = 1'b0;
    bit exp_r1 = 1'b0;
    bit exp_rv = 1'b0;
    bit exp_busy = 1'b0;

    logic [4:0] op_tab [5] = '{OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB};

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus the model's view of that cycle.
    task automatic cycle(input bit v0, input logic [W-1:0] a0,
                         input logic [W-1:0] b0, input logic [4:0] o0,
                         input bit v1, input logic [W-1:0] a1,
                         input logic [W-1:0] b1, input logic [4:0] o1,
                         input bit rr);
        bit w;
        @(posedge clk);
        #1;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
        rsp_ready  = rr;
        exp_busy = m_busy;
        exp_r0 = 1'b0;
        exp_r1 = 1'b0;
        exp_rv = 1'b0;
        if (!m_busy) begin
            if (v0 || v1) begin
                w = (v0 && v1) ? !m_last : v1;
                if (w) sb.push_back({1'b1, alu_model(a1, b1, o1)});
                else   sb.push_back({1'b0, alu_model(a0, b0, o0)});
                exp_r0 = !w;
                exp_r1 = w;
                m_last = w;
                m_busy = 1'b1;
                m_rsp_at = m_cyc + LAT + 1;
                accepts++;
            end
        end else if (m_cyc >= m_rsp_at) begin
            exp_rv = 1'b1;
            if (rr) m_busy = 1'b0;
        end
        m_cyc++;
    endtask

    task automatic idle_cycle(input bit rr);
        cycle(0, '0, '0, '0, 0, '0, '0, '0, rr);
    endtask

    task automatic rnd_cycle();
        cycle($urandom_range(0, 99) < 55, $urandom, $urandom,
              op_tab[$urandom_range(0, 4)],
              $urandom_range(0, 99) < 55, $urandom, $urandom,
              op_tab[$urandom_range(0, 4)],
              $urandom_range(0, 99) < 70);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && m_busy; i++) idle_cycle(1'b1);
        chk1("drain_timeout", m_busy, 1'b0);
    endtask

    task automatic mid_reset();
        drain();
        cycle(1, 32'd100, 32'd1, OP_SUB, 0, '0, '0, '0, 1);
        @(posedge clk);
        #1;
        chk1("exec_busy", busy, 1'b1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst_ni = 1'b0;
        #1;
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chkw("rst_alu_op", {27'd0, alu_op}, '0);
        chkw("rst_alu_a", alu_a, '0);
        chk1("rst_ready0", req0_ready, 1'b0);
        chk1("rst_ready1", req1_ready, 1'b0);
        aborted += sb.size();
        sb.delete();
        m_busy = 1'b0;
        m_last = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp_r0 = 1'b0;
        exp_r1 = 1'b0;
        exp_rv = 1'b0;
        exp_busy = 1'b0;
        rst_ni = 1'b1;
    endtask

    // Monitor: per-cycle handshake checks and scoreboard pops.
    always @(negedge clk) begin
        if (rst_ni) begin
            chk1("ready0", req0_ready, exp_r0);
            chk1("ready1", req1_ready, exp_r1);
            chk1("rsp_valid", rsp_valid, exp_rv);
            chk1("busy", busy, exp_busy);
            if (req0_ready || req1_ready) grants_seen++;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got id %0b result %0h expected no response",
                             rsp_id, rsp_result);
                end else begin
                    chk1("rsp_id", rsp_id, sb[0][W]);
                    chkw("rsp_result", rsp_result, sb[0][W-1:0]);
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #3;
        chk1("reset_ready0", req0_ready, 1'b0);
        chk1("reset_ready1", req1_ready, 1'b0);
        chk1("reset_rsp_valid", rsp_valid, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_rsp_id", rsp_id, 1'b0);
        chkw("reset_rsp_result", rsp_result, '0);
        chkw("reset_alu_a", alu_a, '0);
        chkw("reset_alu_b", alu_b, '0);
        chkw("reset_alu_op", {27'd0, alu_op}, '0);
        #18;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        rst_ni = 1'b1;

        // single request: 5 + 3
        cycle(1, 32'd5, 32'd3, OP_ADD, 0, '0, '0, '0, 1);
        drain();

        // tie after reset-state last: req0 first, then req1
        cycle(1, 32'd10, 32'd4, OP_SUB, 1, 32'd1, 32'd1, OP_ADD, 1);
        target = accepts + 1;
        for (int i = 0; i < 20 && accepts < target; i++)
            cycle(0, '0, '0, '0, 1, 32'd1, 32'd1, OP_ADD, 1);
        drain();

        // fairness: both held valid for six grants
        target = accepts + 6;
        for (int i = 0; i < 80 && accepts < target; i++)
            cycle(1, 32'd20 + W'(i), 32'd7, OP_ADD,
                  1, 32'hF0F0 + W'(i), 32'h0FF0, OP_XOR, 1);
        drain();

        // backpressure: hold the response with both requesters waiting
        cycle(1, 32'd7, 32'd9, OP_OR, 0, '0, '0, '0, 0);
        for (int i = 0; i < LAT + 6; i++)
            cycle(1, 32'd7, 32'd9, OP_OR, 1, 32'd3, 32'd6, OP_AND, 0);
        cycle(1, 32'd7, 32'd9, OP_OR, 1, 32'd3, 32'd6, OP_AND, 1);
        cycle(1, 32'd7, 32'd9, OP_OR, 1, 32'd3, 32'd6, OP_AND, 1);
        drain();

        // reset while executing
        mid_reset();
        for (int i = 0; i < 8; i++) idle_cycle(1'b1);
        cycle(1, 32'd2, 32'd2, OP_ADD, 1, 32'd9, 32'd4, OP_SUB, 1);
        drain();

        // random traffic
        for (int i = 0; i < 600; i++) rnd_cycle();
        drain();
        idle_cycle(1'b1);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_empty: got %0d pending expected 0", sb.size());
        end
        checks++;
        if (pops != accepts - aborted) begin
            errors++;
            $display("FAIL rsp_count: got %0d expected %0d", pops, accepts - aborted);
        end
        checks++;
        if (grants_seen != accepts) begin
            errors++;
            $display("FAIL grant_count: got %0d expected %0d", grants_seen, accepts);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
